// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and are serialized LSB first on txd, back-to-back while the FIFO holds data.
module uart_tx_buf #(
    parameter  int CLK_FREQ   = 100000000,
    parameter  int BAUD       = 115200,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld_tx,
    input  logic [7:0]    d_tx,
    output logic          rdy_tx,
    output logic          txd,
    output logic          busy,
    output logic [AW:0]   cnt
);

    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int BW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DIV_M1 = DIV - 1;

    localparam logic [BW-1:0] BAUD_RELOAD = DIV_M1[BW-1:0];
    localparam logic [AW:0]   FULL_CNT    = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    sh, sh_d;
    logic          txd_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [7:0]    head;

    assign rdy_tx = (cnt != FULL_CNT);
    assign push   = vld_tx && rdy_tx;
    assign head   = mem[rd_ptr];
    assign busy   = (state != IDLE) || (cnt != '0);

    // NOTE: storage array has no reset; only pointers and cnt define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= d_tx;
        end
    end

    // Occupancy is tracked explicitly so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            sh      <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_idx <= bit_idx_d;
            sh      <= sh_d;
            txd     <= txd_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        state_d   = state;
        baud_d    = baud;
        bit_idx_d = bit_idx;
        sh_d      = sh;
        txd_d     = txd;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (cnt != '0) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    baud_d  = BAUD_RELOAD;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (baud == '0) begin
                    txd_d     = sh[0];
                    bit_idx_d = '0;
                    baud_d    = BAUD_RELOAD;
                    state_d   = DATA;
                end else begin
                    baud_d = baud - 1'b1;
                end
            end

            DATA: begin
                if (baud == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        sh_d      = sh >> 1;
                        txd_d     = sh[1];
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end else begin
                    baud_d = baud - 1'b1;
                end
            end

            STOP: begin
                if (baud == '0) begin
                    // Chain straight into the next start bit when more data waits.
                    if (cnt != '0) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        baud_d  = BAUD_RELOAD;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud - 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: default-rate instance for timing/reset,
// DIV=4 instance checked cycle by cycle against a frame-timeline model.
module tb_uart_tx_buf;

    localparam int DB    = 100000000 / 115200;
    localparam int DS    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       b_rst, b_vld, b_rdy, b_txd, b_busy;
    logic [7:0] b_d;
    logic [4:0] b_cnt;
    logic       s_rst, s_vld, s_rdy, s_txd, s_busy;
    logic [7:0] s_d;
    logic [4:0] s_cnt;

    uart_tx_buf dut_b (
        .clk(clk), .rst(b_rst), .vld_tx(b_vld), .d_tx(b_d),
        .rdy_tx(b_rdy), .txd(b_txd), .busy(b_busy), .cnt(b_cnt)
    );

    uart_tx_buf #(.CLK_FREQ(1000), .BAUD(250), .FIFO_DEPTH(DEPTH)) dut_s (
        .clk(clk), .rst(s_rst), .vld_tx(s_vld), .d_tx(s_d),
        .rdy_tx(s_rdy), .txd(s_txd), .busy(s_busy), .cnt(s_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, cycles left in the frame on the line, byte on the line.
    logic [7:0] m_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] mon_q[$];
    int         m_r;
    logic [7:0] m_cur;
    logic       m_acc;
    int         s_cnt_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot i of an 8N1 frame (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic tick_s(input logic v, input logic [7:0] d);
        logic acc, pop;
        s_vld = v;
        s_d   = d;
        acc   = v && (m_q.size() != DEPTH);
        pop   = (m_q.size() != 0) && (m_r <= 1);
        @(posedge clk);
        #1;
        if (pop) begin
            m_cur = m_q.pop_front();
            m_r   = 10 * DS;
        end else if (m_r > 0) begin
            m_r--;
        end
        if (acc) begin
            m_q.push_back(d);
            sent_q.push_back(d);
        end
        m_acc = acc;
        check("s_txd", s_txd, (m_r == 0) ? 1'b1 : frame_bit(m_cur, (10 * DS - m_r) / DS));
        check("s_cnt", s_cnt, 32'(m_q.size()));
        check("s_rdy", s_rdy, m_q.size() != DEPTH);
        check("s_busy", s_busy, (m_r != 0) || (m_q.size() != 0));
        if (int'(s_cnt) > s_cnt_max) s_cnt_max = int'(s_cnt);
    endtask

    task automatic drain_s();
        for (int i = 0; i < 5000; i++) begin
            if (m_r == 0 && m_q.size() == 0) break;
            tick_s(1'b0, 8'h00);
        end
        check("drain_idle", s_busy, 1'b0);
    endtask

    // Independent line monitor: finds the start edge and samples mid-bit.
    logic       mon_act = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_pos = 0;
    int         mon_bad = 0;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin
        if (s_rst) begin
            mon_act  = 1'b0;
            mon_prev = 1'b1;
        end else begin
            if (!mon_act) begin
                if (mon_prev && !s_txd) begin
                    mon_act = 1'b1;
                    mon_pos = 0;
                end
            end else begin
                mon_pos++;
                if (mon_pos % DS == DS / 2) begin
                    if (mon_pos / DS == 0) begin
                        if (s_txd) mon_act = 1'b0;
                    end else if (mon_pos / DS <= 8) begin
                        mon_sh[mon_pos / DS - 1] = s_txd;
                    end else begin
                        if (!s_txd) mon_bad++;
                        mon_q.push_back(mon_sh);
                        mon_act = 1'b0;
                    end
                end
            end
            mon_prev = s_txd;
        end
    end

    initial begin
        int  busy_len;
        int  rdy_cycles;
        logic       pend;
        logic [7:0] pdat;

        b_rst = 1'b1; s_rst = 1'b1;
        b_vld = 1'b0; s_vld = 1'b0;
        b_d   = 8'h00; s_d = 8'h00;
        m_r   = 0; m_cur = 8'h00; m_acc = 1'b0; s_cnt_max = 0;

        // Reset state, immediately and after five cycles of reset.
        #1;
        check("rst_b_txd", b_txd, 1'b1);
        check("rst_s_txd", s_txd, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_b_txd5", b_txd, 1'b1);
        check("rst_b_rdy5", b_rdy, 1'b1);
        check("rst_b_cnt5", b_cnt, 5'd0);
        check("rst_b_busy5", b_busy, 1'b0);
        check("rst_s_rdy5", s_rdy, 1'b1);
        check("rst_s_cnt5", s_cnt, 5'd0);
        check("rst_s_busy5", s_busy, 1'b0);
        b_rst = 1'b0;
        s_rst = 1'b0;

        // Single 0xA5 at DIV=868: every cycle of the frame and the busy drop.
        b_d = 8'hA5; b_vld = 1'b1;
        @(posedge clk); #1;
        b_vld = 1'b0;
        check("b_cnt_push", b_cnt, 5'd1);
        check("b_txd_push", b_txd, 1'b1);
        check("b_busy_push", b_busy, 1'b1);
        @(posedge clk); #1;
        check("b_cnt_pop", b_cnt, 5'd0);
        for (int p = 0; p <= 10 * DB; p++) begin
            check("b_txd", b_txd, (p < 10 * DB) ? frame_bit(8'hA5, p / DB) : 1'b1);
            check("b_busy", b_busy, p < 10 * DB);
            if (p < 10 * DB) begin
                @(posedge clk); #1;
            end
        end

        // Reset 300 cycles into a frame aborts it with txd high at once.
        b_d = 8'h3C; b_vld = 1'b1;
        @(posedge clk); #1;
        b_vld = 1'b0;
        @(posedge clk); #1;
        repeat (300) @(posedge clk);
        #1;
        check("b_pre_abort_txd", b_txd, 1'b0);
        #2;
        b_rst = 1'b1;
        #1;
        check("b_abort_txd", b_txd, 1'b1);
        check("b_abort_cnt", b_cnt, 5'd0);
        check("b_abort_busy", b_busy, 1'b0);
        check("b_abort_rdy", b_rdy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        b_rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            check("b_post_abort_txd", b_txd, 1'b1);
            check("b_post_abort_busy", b_busy, 1'b0);
        end

        // DIV=4 single byte 0x3C: 40-cycle frame, busy from push to frame end.
        repeat (3) tick_s(1'b0, 8'h00);
        busy_len = 0;
        tick_s(1'b1, 8'h3C);
        if (s_busy) busy_len++;
        for (int i = 0; i < 45; i++) begin
            tick_s(1'b0, 8'h00);
            if (s_busy) busy_len++;
        end
        check("s_busy_len", busy_len, 10 * DS + 1);

        // Burst of three on consecutive cycles.
        s_cnt_max = 0;
        tick_s(1'b1, 8'h00);
        tick_s(1'b1, 8'hFF);
        tick_s(1'b1, 8'h55);
        drain_s();
        check("burst_peak", s_cnt_max, 2);

        // Fill: vld held for 20 cycles with incrementing data.
        for (int i = 0; i < 20; i++) tick_s(1'b1, 8'(i));
        check("fill_cnt", s_cnt, 5'd16);
        check("fill_rdy", s_rdy, 1'b0);
        rdy_cycles = 0;
        for (int i = 20; i < 50; i++) begin
            tick_s(1'b1, 8'(i));
            if (s_rdy) rdy_cycles++;
        end
        check("fill_rdy_window", rdy_cycles, 1);
        s_vld = 1'b0;
        drain_s();

        // Push on the frame-end pop edge with four queued.
        for (int i = 0; i < 5; i++) tick_s(1'b1, 8'($urandom));
        for (int i = 0; i < 200; i++) begin
            if (m_r == 1 && m_q.size() == 4) break;
            tick_s(1'b0, 8'h00);
        end
        tick_s(1'b1, 8'hC3);
        check("pushpop_cnt", s_cnt, 5'd4);

        // Random traffic honouring the hold-until-ready rule.
        pend = 1'b0;
        pdat = 8'h00;
        for (int i = 0; i < 1200; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pdat = 8'($urandom);
            end
            tick_s(pend, pdat);
            if (m_acc) pend = 1'b0;
        end
        drain_s();
        repeat (3) tick_s(1'b0, 8'h00);

        // Line-decoded bytes against everything accepted.
        check("mon_count", mon_q.size(), sent_q.size());
        for (int i = 0; i < mon_q.size() && i < sent_q.size(); i++) begin
            check("mon_byte", mon_q[i], sent_q[i]);
        end
        check("stop_bits", mon_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
